// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter: IDLE -> ISSUE -> DONE, one access per 3 cycles.
// Define ARB_RR_EN for round-robin contention; otherwise requester 1 has fixed priority.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module mem_arbiter #(
    parameter int ADDR_W = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req0,
    input  logic                   req1,
    input  logic                   we0,
    input  logic                   we1,
    input  logic [ADDR_W-1:0]      addr0,
    input  logic [ADDR_W-1:0]      addr1,
    input  logic [`WORD_SIZE-1:0]  wdata0,
    input  logic [`WORD_SIZE-1:0]  wdata1,
    output logic                   ack0,
    output logic                   ack1,
    output logic [`WORD_SIZE-1:0]  rdata0,
    output logic [`WORD_SIZE-1:0]  rdata1,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [`WORD_SIZE-1:0]  mem_wdata,
    input  logic [`WORD_SIZE-1:0]  mem_rdata,
    output logic                   busy,
    output logic                   gnt_id
);
    localparam int W = `WORD_SIZE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [W-1:0]      wdata;
    } txn_t;

    state_t       state_q, state_d;
    txn_t         txn_q, txn_d;
    txn_t         win_txn;
    logic         gnt_q, gnt_d;
    logic [W-1:0] rdata0_q, rdata0_d;
    logic [W-1:0] rdata1_q, rdata1_d;
    logic         win;

`ifdef ARB_RR_EN
    // rr_q remembers the last winner; on contention the other requester goes next.
    logic rr_q, rr_d;
    assign win = (req0 && req1) ? ~rr_q : req1;
`else
    assign win = req1;
`endif

    assign win_txn = win ? txn_t'{we: we1, addr: addr1, wdata: wdata1}
                         : txn_t'{we: we0, addr: addr0, wdata: wdata0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            txn_q    <= '0;
            gnt_q    <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            txn_q    <= txn_d;
            gnt_q    <= gnt_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

`ifdef ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_q <= 1'b0;
        else        rr_q <= rr_d;
    end
`endif

    always_comb begin
        state_d   = state_q;
        txn_d     = txn_q;
        gnt_d     = gnt_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ack0      = 1'b0;
        ack1      = 1'b0;
`ifdef ARB_RR_EN
        rr_d      = rr_q;
`endif
        unique case (state_q)
            IDLE: begin
                // Latching here isolates the transaction from later pin changes.
                if (req0 || req1) begin
                    txn_d   = win_txn;
                    gnt_d   = win;
                    state_d = ISSUE;
`ifdef ARB_RR_EN
                    rr_d    = win;
`endif
                end
            end
            ISSUE: begin
                mem_read  = !txn_q.we;
                mem_write = txn_q.we;
                state_d   = DONE;
            end
            DONE: begin
                ack0 = !gnt_q;
                ack1 = gnt_q;
                // Memory registered the read at the end of ISSUE; pass it through and hold it.
                if (!txn_q.we) begin
                    if (gnt_q) rdata1_d = mem_rdata;
                    else       rdata0_d = mem_rdata;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rdata0    = rdata0_d;
    assign rdata1    = rdata1_d;
    assign mem_addr  = txn_q.addr;
    assign mem_wdata = txn_q.wdata;
    assign busy      = (state_q != IDLE);
    assign gnt_id    = gnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a transaction-level model.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module tb_mem_arbiter;
  localparam int AW = 10;
  localparam int W  = `WORD_SIZE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] req = '0, we = '0;
  logic [AW-1:0] addr [2];
  logic [W-1:0] wdata [2];
  logic ack0, ack1, mem_read, mem_write, busy, gnt_id;
  logic [W-1:0] rdata0, rdata1, mem_wdata;
  logic [W-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
    .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .gnt_id(gnt_id)
  );

  // Memory: registered read, write on strobe, plus a bench poke port.
  logic [W-1:0] mem [0:1023];
  logic poke_en = 1'b0;
  logic [AW-1:0] poke_a = '0;
  logic [W-1:0] poke_d = '0;
  always @(posedge clk) begin
    if (poke_en) mem[poke_a] <= poke_d;
    if (mem_read) mem_rdata <= mem[mem_addr];
    if (mem_write) mem[mem_addr] <= mem_wdata;
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [W-1:0] ref_mem [16];
  task automatic poke(input int a, input logic [W-1:0] d);
    poke_en = 1'b1; poke_a = AW'(a); poke_d = d;
    @(negedge clk);
    poke_en = 1'b0;
    if (a < 16) ref_mem[a] = d;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    req = '0; we = '0; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Transaction-level model: a grant is possible once 3 cycles have passed since the last
  // one; strobe one cycle after the grant, ack two cycles after.
  task automatic run_random(input int ncyc);
    bit act[2], granted[2];
    bit pv, pid, pwe, lw, w;
    int pT, free_c;
    logic [AW-1:0] pa, exp_ma;
    logic [W-1:0] pwd, prd;
    logic [W-1:0] exp_rd[2];
    bit e_busy, e_rd, e_wr, e_a0, e_a1;
    act = '{0, 0}; granted = '{0, 0};
    pv = 0; pid = 0; pwe = 0; lw = 0; pT = 0; free_c = 0;
    pa = '0; exp_ma = '0; pwd = '0; prd = '0; exp_rd = '{'0, '0};
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      e_busy = pv && (c == pT + 1 || c == pT + 2);
      e_rd   = pv && c == pT + 1 && !pwe;
      e_wr   = pv && c == pT + 1 && pwe;
      e_a0   = pv && c == pT + 2 && !pid;
      e_a1   = pv && c == pT + 2 && pid;
      if ((e_a0 || e_a1) && !pwe) exp_rd[pid] = prd;
      chk("rnd_busy", busy, e_busy);
      chk("rnd_ack0", ack0, e_a0);
      chk("rnd_ack1", ack1, e_a1);
      chk("rnd_mem_read", mem_read, e_rd);
      chk("rnd_mem_write", mem_write, e_wr);
      chk("rnd_mem_addr", mem_addr, exp_ma);
      chk("rnd_rdata0", rdata0, exp_rd[0]);
      chk("rnd_rdata1", rdata1, exp_rd[1]);
      if (e_busy) chk("rnd_gnt_id", gnt_id, pid);
      if (e_wr) chk("rnd_mem_wdata", mem_wdata, pwd);
      if (pv && c == pT + 2) begin act[pid] = 0; pv = 0; end
      for (int i = 0; i < 2; i++) begin
        if (act[i] && granted[i]) begin
          we[i] = 1'($urandom); addr[i] = AW'($urandom_range(0, 15)); wdata[i] = W'($urandom);
        end else if (act[i] && $urandom_range(0, 7) == 0) begin
          act[i] = 0;
        end else if (!act[i] && $urandom_range(0, 1) == 1) begin
          act[i] = 1; granted[i] = 0;
          we[i] = 1'($urandom); addr[i] = AW'($urandom_range(0, 15)); wdata[i] = W'($urandom);
        end
        req[i] = act[i];
      end
      if (c >= free_c && (act[0] || act[1])) begin
`ifdef ARB_RR_EN
        w = (act[0] && act[1]) ? !lw : act[1];
`else
        w = act[1];
`endif
        lw = w; pv = 1; pT = c; free_c = c + 3; pid = w; granted[w] = 1;
        pwe = we[w]; pa = addr[w]; pwd = wdata[w]; exp_ma = pa;
        if (pwe) ref_mem[pa[3:0]] = pwd;
        else prd = ref_mem[pa[3:0]];
      end
    end
    req = '0;
  endtask

  int k;
  initial begin
    addr = '{'0, '0}; wdata = '{'0, '0};
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_gnt_id", gnt_id, 0);
    poke(5, 16'h00A5); poke(9, 16'h0099); poke(3, 16'h1111); poke(7, 16'h0000);
    do_reset();

    // Read of addr 5 by requester 0.
    req[0] = 1; we[0] = 0; addr[0] = 5;
    tick();
    chk("rd_mem_read", mem_read, 1);
    chk("rd_mem_write", mem_write, 0);
    chk("rd_mem_addr", mem_addr, 5);
    chk("rd_busy", busy, 1);
    chk("rd_ack0_early", ack0, 0);
    tick();
    chk("rd_ack0", ack0, 1);
    chk("rd_ack1", ack1, 0);
    chk("rd_rdata0", rdata0, 16'h00A5);
    chk("rd_strobe_low", mem_read, 0);
    req[0] = 0;
    repeat (3) tick();
    chk("rd_rdata0_hold", rdata0, 16'h00A5);
    chk("rd_idle_busy", busy, 0);
    chk("rd_idle_ack0", ack0, 0);

    // Write 0x1234 to addr 7 by requester 1, then read it back via requester 0.
    req[1] = 1; we[1] = 1; addr[1] = 7; wdata[1] = 16'h1234;
    tick();
    chk("wr_mem_write", mem_write, 1);
    chk("wr_mem_read", mem_read, 0);
    chk("wr_mem_addr", mem_addr, 7);
    chk("wr_mem_wdata", mem_wdata, 16'h1234);
    tick();
    chk("wr_ack1", ack1, 1);
    chk("wr_ack0", ack0, 0);
    chk("wr_strobe_low", mem_write, 0);
    chk("wr_rdata1_keep", rdata1, 0);
    chk("wr_rdata0_keep", rdata0, 16'h00A5);
    req[1] = 0;
    tick();
    req[0] = 1; we[0] = 0; addr[0] = 7;
    repeat (2) tick();
    chk("rbw_ack0", ack0, 1);
    chk("rbw_rdata0", rdata0, 16'h1234);
    req[0] = 0;
    tick();
    chk("rbw_rdata0_hold", rdata0, 16'h1234);

    // Pin changes after grant must not leak into the transaction.
    req[0] = 1; we[0] = 0; addr[0] = 5;
    tick();
    addr[0] = 9; we[0] = 1; wdata[0] = 16'hFFFF;
    #1;
    chk("iso_mem_addr", mem_addr, 5);
    chk("iso_mem_read", mem_read, 1);
    chk("iso_mem_write", mem_write, 0);
    tick();
    chk("iso_ack0", ack0, 1);
    chk("iso_rdata0", rdata0, 16'h00A5);
    chk("iso_addr_hold", mem_addr, 5);
    req[0] = 0;
    tick();

    // Sustained contention for 12 cycles.
    do_reset();
    req = 2'b11; we = 2'b00; addr[0] = 1; addr[1] = 2;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      chk("arb_excl", ack0 && ack1, 0);
      if (ack0 || ack1) begin
`ifdef ARB_RR_EN
        chk("arb_order", ack1, (k % 2) == 0);
`else
        chk("arb_order", ack1, 1);
`endif
        k++;
      end
    end
    chk("arb_count", k, 4);
    req = '0;
    tick();

    // Requester 0 drops its request while the arbiter is busy: never acked.
    req[1] = 1; we[1] = 0; addr[1] = 2;
    tick();
    req[0] = 1; we[0] = 0; addr[0] = 3;
    tick();
    chk("drop_ack1", ack1, 1);
    req = '0;
    repeat (4) begin
      tick();
      chk("drop_ack0", ack0, 0);
      chk("drop_busy", busy, 0);
    end

    // Reset during the ISSUE cycle of a write.
    req[1] = 1; we[1] = 1; addr[1] = 3; wdata[1] = 16'h5555;
    tick();
    chk("abort_pre_write", mem_write, 1);
    rst_n = 0;
    #1;
    chk("abort_mem_write", mem_write, 0);
    chk("abort_mem_read", mem_read, 0);
    chk("abort_busy", busy, 0);
    chk("abort_gnt_id", gnt_id, 0);
    chk("abort_mem_addr", mem_addr, 0);
    req = '0;
    tick();
    rst_n = 1;
    tick();
    chk("abort_idle_busy", busy, 0);
    chk("abort_no_ack1", ack1, 0);
    tick();
    chk("abort_no_ack1_late", ack1, 0);
    chk("abort_mem3", mem[3], 16'h1111);
    req[1] = 1; we[1] = 0; addr[1] = 3;
    repeat (2) tick();
    chk("rereq_ack1", ack1, 1);
    chk("rereq_rdata1", rdata1, 16'h1111);
    req = '0;
    tick();

    // Random traffic over a small address window.
    for (int a = 0; a < 16; a++) poke(a, W'($urandom));
    do_reset();
    run_random(600);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
